// File: rtl/regbank_dump.sv
// regbank_dump
// Shadow mirror of the Micro_MIPS register bank with an ordered, on-demand
// dump port. Both writeback ports are snooped every cycle, independent of the
// dump, so the mirror always tracks the real bank.
//
// Ports
//   reloj                    clock, rising edge
//   resetM                   asynchronous active-low reset
//   REG_WR1/DIR_WRA1/DI_banco1  write port 1 (enable active-low)
//   REG_WR2/DIR_WRA2/DI_banco2  write port 2 (enable active-low, wins ties)
//   start                    dump request, honoured only while idle
//   busy                     high whenever a dump is in progress
//   dump_valid/dump_ready    beat handshake
//   dump_addr/dump_data      register index and value of the beat
//   dump_last                final beat of the dump
//   done                     one-cycle pulse after the final handshake
module regbank_dump #(
  parameter int DEPTH          = 32,
  parameter int AW             = 5,
  parameter int DW             = 32,
  parameter bit SKIP_UNWRITTEN = 1'b0
) (
  input  logic          reloj,
  input  logic          resetM,
  input  logic          REG_WR1,
  input  logic [AW-1:0] DIR_WRA1,
  input  logic [DW-1:0] DI_banco1,
  input  logic          REG_WR2,
  input  logic [AW-1:0] DIR_WRA2,
  input  logic [DW-1:0] DI_banco2,
  input  logic          start,
  output logic          busy,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [AW-1:0] dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_last,
  output logic          done
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [AW-1:0]      r_ptr;
  logic [DW-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]   r_written;

  logic               w_qual;
  logic               w_later_written;
  logic               w_last;

  // Mirror update. Port 2 is assigned second so it wins a same-address tie.
  // Address 0 models the hardwired zero register and is never written.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_written <= '0;
    end else begin
      if (!REG_WR1 && (DIR_WRA1 != '0)) begin
        r_mem[DIR_WRA1]     <= DI_banco1;
        r_written[DIR_WRA1] <= 1'b1;
      end
      if (!REG_WR2 && (DIR_WRA2 != '0)) begin
        r_mem[DIR_WRA2]     <= DI_banco2;
        r_written[DIR_WRA2] <= 1'b1;
      end
    end
  end

  // Any written entry strictly above the current pointer, using the written
  // bits as they stand before this edge's writes land.
  always_comb begin
    w_later_written = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((i > int'(r_ptr)) && r_written[i]) begin
        w_later_written = 1'b1;
      end
    end
  end

  assign w_qual = !SKIP_UNWRITTEN || r_written[r_ptr];
  assign w_last = SKIP_UNWRITTEN ? !w_later_written : (r_ptr == LAST_PTR);

  // Dump sequencer. All outputs are registered here. Capture reads the
  // committed mirror value, so a write on the capture edge is not bypassed.
  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      busy       <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_ptr   <= '0;
            busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!w_qual) begin
            if (r_ptr == LAST_PTR) begin
              r_state <= S_FIN;
              done    <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end else begin
            dump_addr  <= r_ptr;
            dump_data  <= r_mem[r_ptr];
            dump_last  <= w_last;
            dump_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            if (dump_last) begin
              r_state <= S_FIN;
              done    <= 1'b1;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_dump.sv
// Bench for regbank_dump: two instances (all entries / written entries only)
// share every input; a spec-level model predicts each instance's outputs.
module tb_regbank_dump;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          reloj = 1'b0;
  logic          resetM = 1'b0;
  logic          REG_WR1 = 1'b1;
  logic [AW-1:0] DIR_WRA1 = '0;
  logic [DW-1:0] DI_banco1 = '0;
  logic          REG_WR2 = 1'b1;
  logic [AW-1:0] DIR_WRA2 = '0;
  logic [DW-1:0] DI_banco2 = '0;
  logic          start = 1'b0;
  logic          dump_ready = 1'b1;

  logic          busy0, dv0, dl0, dn0;
  logic [AW-1:0] da0;
  logic [DW-1:0] dd0;
  logic          busy1, dv1, dl1, dn1;
  logic [AW-1:0] da1;
  logic [DW-1:0] dd1;

  regbank_dump #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SKIP_UNWRITTEN(1'b0)) u_all (
    .reloj(reloj), .resetM(resetM),
    .REG_WR1(REG_WR1), .DIR_WRA1(DIR_WRA1), .DI_banco1(DI_banco1),
    .REG_WR2(REG_WR2), .DIR_WRA2(DIR_WRA2), .DI_banco2(DI_banco2),
    .start(start), .busy(busy0), .dump_valid(dv0), .dump_ready(dump_ready),
    .dump_addr(da0), .dump_data(dd0), .dump_last(dl0), .done(dn0)
  );

  regbank_dump #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .SKIP_UNWRITTEN(1'b1)) u_skip (
    .reloj(reloj), .resetM(resetM),
    .REG_WR1(REG_WR1), .DIR_WRA1(DIR_WRA1), .DI_banco1(DI_banco1),
    .REG_WR2(REG_WR2), .DIR_WRA2(DIR_WRA2), .DI_banco2(DI_banco2),
    .start(start), .busy(busy1), .dump_valid(dv1), .dump_ready(dump_ready),
    .dump_addr(da1), .dump_data(dd1), .dump_last(dl1), .done(dn1)
  );

  initial forever #5 reloj = ~reloj;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge reloj) cyc <= cyc + 1;

  typedef struct {
    int          a;
    logic [31:0] d;
    bit          l;
  } beat_t;
  beat_t lg0[$];
  beat_t lg1[$];
  int    dc[2];
  int    dcyc[2];

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_wr  [DEPTH];
  bit            m_scan[2], m_beat[2], m_fin[2], m_last[2];
  int            m_cur[2], m_addr[2];
  logic [DW-1:0] m_data[2];

  function automatic bit written_above(input int a);
    for (int j = a + 1; j < DEPTH; j++) if (m_wr[j]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input int i);
    if (m_fin[i]) begin
      m_fin[i] = 1'b0;
    end else if (m_beat[i]) begin
      if (dump_ready) begin
        m_beat[i] = 1'b0;
        if (m_last[i]) m_fin[i] = 1'b1;
        else begin
          m_scan[i] = 1'b1;
          m_cur[i]  = m_addr[i] + 1;
        end
      end
    end else if (m_scan[i]) begin
      if (i == 1 && !m_wr[m_cur[i]]) begin
        if (m_cur[i] == DEPTH - 1) begin
          m_scan[i] = 1'b0;
          m_fin[i]  = 1'b1;
        end else m_cur[i] = m_cur[i] + 1;
      end else begin
        m_addr[i] = m_cur[i];
        m_data[i] = m_mem[m_cur[i]];
        m_last[i] = (i == 1) ? !written_above(m_cur[i]) : (m_cur[i] == DEPTH - 1);
        m_scan[i] = 1'b0;
        m_beat[i] = 1'b1;
      end
    end else if (start) begin
      m_scan[i] = 1'b1;
      m_cur[i]  = 0;
    end
  endtask

  always @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_mem[k] = '0;
        m_wr[k]  = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        m_scan[i] = 1'b0; m_beat[i] = 1'b0; m_fin[i] = 1'b0; m_last[i] = 1'b0;
        m_cur[i] = 0; m_addr[i] = 0; m_data[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) step(i);
      if (!REG_WR1 && DIR_WRA1 != 0) begin
        m_mem[DIR_WRA1] = DI_banco1;
        m_wr[DIR_WRA1]  = 1'b1;
      end
      if (!REG_WR2 && DIR_WRA2 != 0) begin
        m_mem[DIR_WRA2] = DI_banco2;
        m_wr[DIR_WRA2]  = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  task automatic cmp(input int i, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL d%0d %s cyc %0d got %0h want %0h", i, nm, cyc, act, exp);
    end
  endtask

  task automatic check_dut(input int i, input logic b, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic l, input logic n);
    cmp(i, "busy", b, m_scan[i] | m_beat[i] | m_fin[i]);
    cmp(i, "valid", v, m_beat[i]);
    cmp(i, "done", n, m_fin[i]);
    if (v === 1'b1 && m_beat[i]) begin
      cmp(i, "addr", a, m_addr[i]);
      cmp(i, "data", d, m_data[i]);
      cmp(i, "last", l, m_last[i]);
    end
    if (v === 1'b1 && dump_ready) begin
      if (i == 0) lg0.push_back('{int'(a), d, l});
      else        lg1.push_back('{int'(a), d, l});
    end
    if (n === 1'b1) begin
      dc[i]++;
      dcyc[i] = cyc;
    end
  endtask

  always @(negedge reloj) begin
    if (cyc > 0) begin
      check_dut(0, busy0, dv0, da0, dd0, dl0, dn0);
      check_dut(1, busy1, dv1, da1, dd1, dl1, dn1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic e1, input int a1, input logic [31:0] d1,
                    input logic e2, input int a2, input logic [31:0] d2);
    REG_WR1 = !e1; DIR_WRA1 = AW'(a1); DI_banco1 = d1;
    REG_WR2 = !e2; DIR_WRA2 = AW'(a2); DI_banco2 = d2;
    tick();
    REG_WR1 = 1'b1; REG_WR2 = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) chk("idle timeout", 64'd1, 64'd0);
  endtask

  task automatic begin_dump(output int s);
    lg0.delete(); lg1.delete();
    dc[0] = 0; dc[1] = 0;
    start = 1'b1;
    s = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int s;
    int n;
    int stall_a;

    // reset values
    tick(); tick(); tick();
    chk("rst busy0", busy0, 0);  chk("rst valid0", dv0, 0);
    chk("rst addr0", da0, 0);    chk("rst data0", dd0, 0);
    chk("rst last0", dl0, 0);    chk("rst done0", dn0, 0);
    chk("rst busy1", busy1, 0);  chk("rst valid1", dv1, 0);
    chk("rst addr1", da1, 0);    chk("rst data1", dd1, 0);
    chk("rst last1", dl1, 0);    chk("rst done1", dn1, 0);
    resetM = 1'b1;
    tick();

    // full dump of a clean mirror
    begin_dump(s);
    wait_idle();
    chk("t1 beats0", lg0.size(), 32);
    if (lg0.size() == 32)
      for (int i = 0; i < 32; i++) begin
        chk("t1 addr", lg0[i].a, i);
        chk("t1 data", lg0[i].d, 0);
        chk("t1 last", lg0[i].l, (i == 31));
      end
    chk("t1 beats1", lg1.size(), 0);
    chk("t1 done0", dc[0], 1);
    chk("t1 done1", dc[1], 1);
    chk("t1 len0", dcyc[0] - s, 64);
    chk("t1 len1", dcyc[1] - s, 32);

    // written-only dump
    wr(1, 3, 32'h11111111, 1, 31, 32'h22222222);
    begin_dump(s);
    wait_idle();
    chk("t2 beats1", lg1.size(), 2);
    if (lg1.size() == 2) begin
      chk("t2 a0", lg1[0].a, 3);  chk("t2 d0", lg1[0].d, 32'h11111111); chk("t2 l0", lg1[0].l, 0);
      chk("t2 a1", lg1[1].a, 31); chk("t2 d1", lg1[1].d, 32'h22222222); chk("t2 l1", lg1[1].l, 1);
    end
    chk("t2 beats0", lg0.size(), 32);
    if (lg0.size() == 32) chk("t2 r31", lg0[31].d, 32'h22222222);

    // same-address tie and R0 write
    wr(1, 5, 32'hDEADBEEF, 1, 5, 32'h12345678);
    wr(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0);
    begin_dump(s);
    wait_idle();
    chk("t3 beats0", lg0.size(), 32);
    if (lg0.size() == 32) begin
      chk("t3 r5", lg0[5].d, 32'h12345678);
      chk("t3 r0", lg0[0].d, 32'h0);
    end
    chk("t3 beats1", lg1.size(), 3);
    if (lg1.size() == 3) begin
      chk("t3 s1a", lg1[1].a, 5);
      chk("t3 s1d", lg1[1].d, 32'h12345678);
    end

    // back-pressure in the middle of a dump
    begin_dump(s);
    n = 0;
    while (!(dv0 && da0 == 5'd10) && n < 100) begin
      tick();
      n++;
    end
    chk("t4 reach", n < 100, 1);
    dump_ready = 1'b0;
    stall_a = int'(da0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4 hold valid", dv0, 1);
      chk("t4 hold addr", da0, stall_a);
    end
    dump_ready = 1'b1;
    wait_idle();
    chk("t4 beats0", lg0.size(), 32);
    if (lg0.size() == 32)
      for (int i = 0; i < 32; i++) chk("t4 order", lg0[i].a, i);

    // snapshot semantics: R2 after it was sent, R20 before capture
    begin_dump(s);
    n = 0;
    while (lg0.size() < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5 reach", n < 100, 1);
    wr(1, 2, 32'hAAAAAAAA, 1, 20, 32'hBBBBBBBB);
    wait_idle();
    chk("t5 beats0", lg0.size(), 32);
    if (lg0.size() == 32) begin
      chk("t5 r2 old", lg0[2].d, 32'h0);
      chk("t5 r20 new", lg0[20].d, 32'hBBBBBBBB);
    end
    begin_dump(s);
    wait_idle();
    if (lg0.size() == 32) chk("t5b r2", lg0[2].d, 32'hAAAAAAAA);
    else chk("t5b beats0", lg0.size(), 32);
    chk("t5b beats1", lg1.size(), 5);

    // reset abort in SEND at addr 7
    begin_dump(s);
    n = 0;
    while (!(dv0 && da0 == 5'd7) && n < 100) begin
      tick();
      n++;
    end
    chk("t6 reach", n < 100, 1);
    resetM = 1'b0;
    #1;
    chk("t6 valid drop", dv0, 0);
    chk("t6 busy drop", busy0, 0);
    tick(); tick();
    resetM = 1'b1;
    tick(); tick();
    chk("t6 no done0", dc[0], 0);
    chk("t6 no done1", dc[1], 0);
    begin_dump(s);
    wait_idle();
    chk("t6 beats0", lg0.size(), 32);
    if (lg0.size() == 32) begin
      chk("t6 first", lg0[0].a, 0);
      for (int i = 0; i < 32; i++) chk("t6 cleared", lg0[i].d, 0);
    end
    chk("t6 beats1", lg1.size(), 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
